// File: rtl/common_pkg.sv
// common_pkg: types shared across the weighted-sum block.
//   ws_state_e : control FSM state (IDLE / ACCUM / DONE)
package common_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } ws_state_e;

endpackage

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: fixed-point constants and helpers shared by the
// weighted-sum datapath.
//   FRAC_BITS_DEFAULT : default number of fractional bits in every operand
//   sat_int()         : clamp a 64-bit signed value into the 32-bit int range
package fixed_point_pkg;

  localparam int unsigned FRAC_BITS_DEFAULT = 8;

  localparam logic signed [63:0] INT_MAX_64 = 64'sd2147483647;
  localparam logic signed [63:0] INT_MIN_64 = -64'sd2147483648;

  function automatic logic signed [31:0] sat_int(input logic signed [63:0] v);
    logic signed [31:0] r;
    if (v > INT_MAX_64)      r = 32'sh7fff_ffff;
    else if (v < INT_MIN_64) r = 32'sh8000_0000;
    else                     r = v[31:0];
    return r;
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// fixed_mul: combinational signed fixed-point multiply.
//   a, b : 32-bit signed operands with FRAC_BITS fractional bits
//   p    : 64-bit full product arithmetically shifted right by FRAC_BITS,
//          i.e. the product re-aligned to FRAC_BITS fractional bits
module fixed_mul #(
  parameter int unsigned FRAC_BITS = fixed_point_pkg::FRAC_BITS_DEFAULT
) (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [63:0] p
);

  logic signed [63:0] a_ext, b_ext, prod;

  always_comb begin
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    // low 64 bits of a 64x64 product of sign-extended 32-bit values is exact
    prod  = a_ext * b_ext;
    p     = prod >>> FRAC_BITS;
  end

endmodule

// File: rtl/weighted_sum.sv
// weighted_sum: accumulates bias + sum(x[i]*w[i]) over N_FEATURES pairs and
// presents the result saturated to 32 bits.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, bias       : begin a sample (IDLE only); bias captured on accept
//   in_valid/in_ready : x/w pair handshake, ready only while accumulating
//   x, w              : fixed-point feature and weight
//   out_valid/out_ready : result handshake
//   sum               : saturated result, 0 whenever no result is held
module weighted_sum
  import fixed_point_pkg::*;
  import common_pkg::*;
#(
  parameter int N_FEATURES         = 4,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] x,
  input  logic signed [31:0] w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] sum
);

  if (N_FEATURES < 1) begin : g_bad_n
    $error("weighted_sum: N_FEATURES must be at least 1");
  end

  localparam int CNT_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEATURES - 1);

  ws_state_e          state_q, state_d;
  logic signed [63:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [63:0] prod;
  logic               accept;

  fixed_mul #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .a (x),
    .b (w),
    .p (prod)
  );

  assign accept = in_valid && (state_q == ACCUM);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and datapath
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = {{32{bias[31]}}, bias};
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + prod;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here, even on the handshake
        // cycle; a new sample can begin from IDLE on the next cycle
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from registered state only, so reset clears them at once
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    sum       = (state_q == DONE) ? sat_int(acc_q) : 32'sd0;
  end

endmodule

// File: tb/tb_weighted_sum.sv
module tb_weighted_sum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic signed [31:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic signed [31:0] x = '0;
  logic signed [31:0] w = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic signed [31:0] sum;

  weighted_sum #(.N_FEATURES(4), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int b;
    int xv[4];
    int wv[4];
    bit gaps;
    int hold;
    int exp;
  } vec_t;

  vec_t vecs[8];
  int   cur_x[4];
  int   cur_w[4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: exact real-number-style sum in 64-bit, each term truncated
  // toward minus infinity by the fractional re-alignment, then clamped
  function automatic int ref_sum(input int b);
    longint acc;
    acc = longint'(b);
    for (int i = 0; i < 4; i++)
      acc += (longint'(cur_x[i]) * longint'(cur_w[i])) >>> 8;
    if (acc > 64'sd2147483647) return 32'sh7fff_ffff;
    if (acc < -64'sd2147483648) return 32'sh8000_0000;
    return int'(acc);
  endfunction

  // One full sample: start, 4 pairs (optionally with gaps and stray start
  // pulses), result hold for 'hold' cycles, handshake with start held high.
  task automatic run_sample(input string tag, input int b, input bit gaps,
                            input int hold, output int got);
    int held;
    @(negedge clk);
    start = 1'b1; bias = b;
    @(negedge clk);
    start = 1'b0; bias = 32'sh5a5a_5a5a;  // later bias changes must not matter
    chk({tag, " in_ready_accum"}, in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0; start = 1'b1;
        x = 32'sd12345; w = 32'sd6789;
        @(negedge clk);
        start = 1'b0;
      end
      in_valid = 1'b1; x = cur_x[i]; w = cur_w[i];
      @(negedge clk);
    end
    in_valid = 1'b0; x = 32'sd999; w = 32'sd999;
    chk({tag, " out_valid_latency"}, out_valid, 1);
    chk({tag, " in_ready_done"}, in_ready, 0);
    held = sum;
    for (int k = 0; k < hold; k++) begin
      start = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_sum"}, sum, held);
    end
    in_valid = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk({tag, " after_hs_valid"}, out_valid, 0);
    chk({tag, " after_hs_sum"}, sum, 0);
    chk({tag, " start_on_hs_ignored"}, in_ready, 0);
    got = held;
  endtask

  initial begin
    int got;
    int r;

    vecs[0] = '{b:0, xv:'{256,256,256,256}, wv:'{128,128,128,128},
                gaps:0, hold:0, exp:512};
    vecs[1] = '{b:-256, xv:'{512,256,-128,0}, wv:'{-256,256,-512,999},
                gaps:0, hold:1, exp:-256};
    vecs[2] = '{b:32'sh7fff_ffff, xv:'{1<<20,1<<20,1<<20,1<<20},
                wv:'{1<<20,1<<20,1<<20,1<<20}, gaps:0, hold:0, exp:32'sh7fff_ffff};
    vecs[3] = '{b:32'sh8000_0000, xv:'{-(1<<20),-(1<<20),-(1<<20),-(1<<20)},
                wv:'{1<<20,1<<20,1<<20,1<<20}, gaps:0, hold:0, exp:32'sh8000_0000};
    vecs[4] = '{b:0, xv:'{256,256,256,256}, wv:'{128,128,128,128},
                gaps:1, hold:5, exp:512};
    vecs[5] = '{b:0, xv:'{-1,-1,-1,-1}, wv:'{1,1,1,1},
                gaps:0, hold:0, exp:-4};
    vecs[6] = '{b:0, xv:'{1,1,1,1}, wv:'{1,1,1,1},
                gaps:1, hold:2, exp:0};
    vecs[7] = '{b:32'sh7fff_ff00, xv:'{256,-256,0,0}, wv:'{256,512,0,0},
                gaps:0, hold:0, exp:32'sh7fff_fe00};

    // reset state
    #2;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle ignores in_valid", in_ready, 0);
    in_valid = 1'b0;

    // directed table
    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        cur_x[i] = vecs[v].xv[i];
        cur_w[i] = vecs[v].wv[i];
      end
      run_sample($sformatf("vec%0d", v), vecs[v].b, vecs[v].gaps,
                 vecs[v].hold, got);
      chk($sformatf("vec%0d sum", v), got, vecs[v].exp);
      chk($sformatf("vec%0d model", v), ref_sum(vecs[v].b), vecs[v].exp);
    end

    // reset in the middle of accumulation
    for (int i = 0; i < 4; i++) begin cur_x[i] = 256; cur_w[i] = 128; end
    @(negedge clk);
    start = 1'b1; bias = 32'sd1000;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; x = 32'sd70000; w = 32'sd70000;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample("post_rst", 0, 0, 0, got);
    chk("post_rst sum", got, 512);

    // reset while a result is pending
    run_sample("pre_done_rst_setup", 0, 0, 0, got);
    @(negedge clk);
    start = 1'b1; bias = 32'sd0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("done_rst pre valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("done_rst out_valid", out_valid, 0);
    chk("done_rst sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("done_rst idle", in_ready, 0);

    // randomized against the reference model
    for (int n = 0; n < 40; n++) begin
      int b;
      bit g;
      int h;
      for (int i = 0; i < 4; i++) begin
        if (n % 2 == 0) begin
          cur_x[i] = $urandom;
          cur_w[i] = $urandom_range(0, 1) ? $urandom : int'($urandom_range(0, 4095)) - 2048;
        end else begin
          cur_x[i] = int'($urandom_range(0, 1 << 20)) - (1 << 19);
          cur_w[i] = int'($urandom_range(0, 1 << 20)) - (1 << 19);
        end
      end
      r = $urandom_range(0, 3);
      b = (r == 0) ? 32'sh7fff_ffff : (r == 1) ? 32'sh8000_0000 : $urandom;
      g = 1'($urandom_range(0, 1));
      h = $urandom_range(0, 3);
      run_sample($sformatf("rnd%0d", n), b, g, h, got);
      chk($sformatf("rnd%0d sum", n), got, ref_sum(b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
